// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: two-flop synchronizer, debounce FSM with one shared
// timer, optional auto-repeat. All outputs are registered and change on the
// same edge as the state transition that causes them.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn_in,
  output logic impulse,
  output logic btn_level,
  output logic held
);

  // Timer only ever counts up to (largest interval - 1), so $clog2 of the
  // largest interval is enough; clamp to one bit for degenerate parameters.
  localparam int MAX_AB   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_ALL  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int TW       = ($clog2(MAX_ALL) > 0) ? $clog2(MAX_ALL) : 1;

  typedef logic [TW-1:0] timer_t;

  localparam timer_t DEB_LAST = timer_t'(DEBOUNCE_CYCLES - 1);
  localparam timer_t DLY_LAST = timer_t'(REPEAT_DELAY - 1);
  localparam timer_t PER_LAST = timer_t'(REPEAT_PERIOD - 1);
  localparam timer_t T_ZERO   = timer_t'(0);
  localparam timer_t T_ONE    = timer_t'(1);
  localparam logic   RPT_ON   = (REPEAT_EN != 0);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    REPEAT       = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  logic   sync1_r;
  logic   sync2_r;
  logic   btn_s;
  state_t state_r;
  timer_t timer_r;
  logic   impulse_r;
  logic   level_r;
  logic   held_r;

  // Two-flop synchronizer: the only logic that samples the raw button.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  assign btn_s = sync2_r;

  // Debounce / auto-repeat FSM with shared timer and registered outputs.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r   <= IDLE;
      timer_r   <= T_ZERO;
      impulse_r <= 1'b0;
      level_r   <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      impulse_r <= 1'b0;
      case (state_r)
        IDLE: begin
          timer_r <= T_ZERO;
          level_r <= 1'b0;
          held_r  <= 1'b0;
          if (btn_s) begin
            state_r <= PRESS_WAIT;
          end else begin
            state_r <= IDLE;
          end
        end
        PRESS_WAIT: begin
          held_r <= 1'b0;
          if (!btn_s) begin
            state_r <= IDLE;
            timer_r <= T_ZERO;
            level_r <= 1'b0;
          end else if (timer_r == DEB_LAST) begin
            state_r   <= PRESSED;
            timer_r   <= T_ZERO;
            impulse_r <= 1'b1;
            level_r   <= 1'b1;
          end else begin
            timer_r <= timer_r + T_ONE;
            level_r <= 1'b0;
          end
        end
        PRESSED: begin
          level_r <= 1'b1;
          // Release beats a coincident repeat expiry.
          if (!btn_s) begin
            state_r <= RELEASE_WAIT;
            timer_r <= T_ZERO;
            held_r  <= 1'b0;
          end else if (!RPT_ON) begin
            timer_r <= T_ZERO;
            held_r  <= 1'b0;
          end else if (timer_r == DLY_LAST) begin
            state_r   <= REPEAT;
            timer_r   <= T_ZERO;
            impulse_r <= 1'b1;
            held_r    <= 1'b1;
          end else begin
            timer_r <= timer_r + T_ONE;
            held_r  <= 1'b0;
          end
        end
        REPEAT: begin
          level_r <= 1'b1;
          if (!btn_s) begin
            state_r <= RELEASE_WAIT;
            timer_r <= T_ZERO;
            held_r  <= 1'b0;
          end else if (timer_r == PER_LAST) begin
            timer_r   <= T_ZERO;
            impulse_r <= 1'b1;
            held_r    <= 1'b1;
          end else begin
            timer_r <= timer_r + T_ONE;
            held_r  <= 1'b1;
          end
        end
        RELEASE_WAIT: begin
          held_r <= 1'b0;
          // A re-press during release debounce is a bounce: back to PRESSED,
          // no impulse, repeat delay starts over.
          if (btn_s) begin
            state_r <= PRESSED;
            timer_r <= T_ZERO;
            level_r <= 1'b1;
          end else if (timer_r == DEB_LAST) begin
            state_r <= IDLE;
            timer_r <= T_ZERO;
            level_r <= 1'b0;
          end else begin
            timer_r <= timer_r + T_ONE;
            level_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          timer_r <= T_ZERO;
          level_r <= 1'b0;
          held_r  <= 1'b0;
        end
      endcase
    end
  end

  assign impulse   = impulse_r;
  assign btn_level = level_r;
  assign held      = held_r;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner. Two instances share the stimulus:
// u_norep (auto-repeat off) and u_rep (auto-repeat on). Expected values are
// hand-computed edge numbers; outputs are sampled 1 time unit after each edge.
module tb_btn_conditioner;

  logic clk;
  logic nrst;
  logic btn_in;
  logic n_imp, n_lvl, n_held;
  logic r_imp, r_lvl, r_held;

  int n_cmp;
  int n_err;
  int n_cnt;
  int r_cnt;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_norep (
    .clk(clk), .nrst(nrst), .btn_in(btn_in),
    .impulse(n_imp), .btn_level(n_lvl), .held(n_held)
  );

  btn_conditioner #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) u_rep (
    .clk(clk), .nrst(nrst), .btn_in(btn_in),
    .impulse(r_imp), .btn_level(r_lvl), .held(r_held)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag,
                           input logic ei_n, input logic el_n, input logic eh_n,
                           input logic ei_r, input logic el_r, input logic eh_r);
    chk({tag, " norep.impulse"}, {31'd0, n_imp},  {31'd0, ei_n});
    chk({tag, " norep.level"},   {31'd0, n_lvl},  {31'd0, el_n});
    chk({tag, " norep.held"},    {31'd0, n_held}, {31'd0, eh_n});
    chk({tag, " rep.impulse"},   {31'd0, r_imp},  {31'd0, ei_r});
    chk({tag, " rep.level"},     {31'd0, r_lvl},  {31'd0, el_r});
    chk({tag, " rep.held"},      {31'd0, r_held}, {31'd0, eh_r});
  endtask

  initial begin
    logic ri;
    n_cmp  = 0;
    n_err  = 0;
    nrst   = 1'b0;
    btn_in = 1'b0;

    // Reset state
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Held press for 30 edges then release: single impulse without repeat,
    // repeats at 17,20,...,32 with repeat; release seen at edge 33,
    // release debounce finishes at edge 37.
    nrst = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      btn_in = (e <= 30) ? 1'b1 : 1'b0;
      tick();
      ri = (e == 7) || (e == 17) || (e == 20) || (e == 23) ||
           (e == 26) || (e == 29) || (e == 32);
      check_all($sformatf("hold e%0d", e),
                (e == 7), (e >= 7 && e < 37), 1'b0,
                ri, (e >= 7 && e < 37), (e >= 17 && e < 33));
    end

    // Bounce 3 high / 1 low for 20 edges, then stable high from edge 21
    // (accepted at edge 27). Low for edges 33,34 is a release bounce: level
    // stays 1, repeat delay restarts from edge 37 -> repeats at 47,50,53.
    for (int e = 1; e <= 54; e++) begin
      if (e <= 20) btn_in = (((e - 1) % 4) != 3) ? 1'b1 : 1'b0;
      else if (e == 33 || e == 34) btn_in = 1'b0;
      else btn_in = 1'b1;
      tick();
      ri = (e == 27) || (e == 47) || (e == 50) || (e == 53);
      check_all($sformatf("bounce e%0d", e),
                (e == 27), (e >= 27), 1'b0,
                ri, (e >= 27), (e >= 47));
    end

    // Reset for two edges while u_rep is in REPEAT with the button held.
    nrst = 1'b0;
    tick();
    check_all("rst_edge1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("rst_edge2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Button still held after reset release: full debounce, one impulse at 7.
    nrst  = 1'b1;
    n_cnt = 0;
    r_cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      btn_in = 1'b1;
      tick();
      n_cnt = n_cnt + int'(n_imp);
      r_cnt = r_cnt + int'(r_imp);
      check_all($sformatf("postrst e%0d", e),
                (e == 7), (e >= 7), 1'b0,
                (e == 7), (e >= 7), 1'b0);
    end

    // Release (seen at edge 3, coinciding with u_rep's repeat-delay expiry,
    // release wins), idle at edge 7, second press accepted at edge 15.
    for (int e = 1; e <= 20; e++) begin
      btn_in = (e >= 9) ? 1'b1 : 1'b0;
      tick();
      n_cnt = n_cnt + int'(n_imp);
      r_cnt = r_cnt + int'(r_imp);
      check_all($sformatf("repress e%0d", e),
                (e == 15), (e < 7 || e >= 15), 1'b0,
                (e == 15), (e < 7 || e >= 15), 1'b0);
    end
    chk("two_presses norep", n_cnt, 32'd2);
    chk("two_presses rep",   r_cnt, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
